mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM pipeline stage of the LoongArch CPU, between EXE and WB.
- Completes data-SRAM loads issued by EXE and aligns/extends load data.
- Forms the 207-bit MEM_to_WB_bus and forwards results and load-use stall info to ID.
- Handles flush, including discarding SRAM responses owed by killed instructions.

Parameters:
- BUS_IN_W, 212, width of EXE_to_MEM_bus.
- BUS_OUT_W, 207, width of MEM_to_WB_bus.
- DISCARD_W, 2, width of the discard counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- EXE_to_MEM_valid  in  1  EXE output valid
- MEM_allow_in  out  1  MEM can accept this cycle
- EXE_to_MEM_bus  in  212  layout: {mem_req_sent[211], ld_type[210:208], res_from_mem[207], wb_fields[206:0]}. wb_fields uses the MEM_to_WB layout, with alu_result (or bad vaddr on exception) in place of final_result.
- exe_killed_req  in  1  EXE instruction killed by flush had an accepted SRAM request
- data_sram_data_ok  in  1  read/write response
- data_sram_rdata  in  32  load data
- WB_allow_in  in  1  WB ready
- MEM_to_WB_valid  out  1
- MEM_to_WB_bus  out  207  {refetch,tlbsrch,tlbrd,tlbwr,tlbfill,tlbhit,tlbhit_idx[3:0],csr_we,csr_num[13:0],csr_wmask[31:0],csr_wvalue[31:0],ertn,ex_type[14:0],final_result[31:0],gr_we,dest[4:0],pc[31:0],inst[31:0]}
- MEM_to_ID_bus  out  39  {fwd_we, fwd_dest[4:0], fwd_data[31:0], load_stall}
- mem_block  out  1  MEM_valid & (ex | ertn | refetch); EXE suppresses stores
- flush  in  1  exception/ertn/refetch flush from WB

Behaviour:
- Reset: MEM_valid=0, bus reg=0, rdata_buf=0, buf_valid=0, discard_cnt=0. All outputs derive from these, so MEM_to_WB_valid=0, MEM_to_ID_bus=0, mem_block=0.
- Capture: bus reg loads EXE_to_MEM_bus when EXE_to_MEM_valid & MEM_allow_in.
- MEM_valid update: if flush, MEM_valid<=0; else if MEM_allow_in, MEM_valid<=EXE_to_MEM_valid.
- ex = |ex_type. need_data = mem_req_sent & ~ex.
- got = buf_valid | (data_sram_data_ok & discard_cnt==0).
- MEM_ready_go = ~need_data | got.
- MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
- MEM_to_WB_valid = MEM_valid & MEM_ready_go & ~flush.
- Response buffering:
  - data_ok arriving with discard_cnt==0, MEM_valid & need_data & ~buf_valid, and WB_allow_in low: rdata_buf<=rdata, buf_valid<=1.
  - buf_valid clears when the instruction hands off to WB or on flush.
- Load extraction uses addr[1:0] = alu_result[1:0]. ld_type: 0=W, 1=B, 2=BU, 3=H, 4=HU.
  - B/BU select byte addr; H/HU select half addr[1].
  - Sign- or zero-extend to 32 bits. Other codes are treated as W.
- final_result = (res_from_mem & ~ex) ? loaded value : alu_result. Same cycle as data_ok, or from the buffer.
- Discard counter, evaluated in the flush cycle:
  - inc = (MEM_valid & need_data & ~got) + exe_killed_req.
  - discard_cnt <= discard_cnt + inc - dec, where dec = data_ok & discard_cnt!=0. Saturates at 3.
  - While nonzero, every data_ok only decrements it and is never delivered.
- Forwarding:
  - fwd_we = MEM_valid & gr_we & ~ex.
  - fwd_data = final_result.
  - load_stall = MEM_valid & res_from_mem & ~MEM_ready_go.
- Stores: a store with mem_req_sent waits for data_ok the same way; rdata is ignored.
- Reset mid-wait clears everything; the SRAM side is reset concurrently.

Decomposition:
- Shared package cpu_defs holds:
  - TYPE_* exception indices 0..14 and EXC_ECODE/ESUBCODE constants.
  - LD_W/LD_B/LD_BU/LD_H/LD_HU encodings.
  - Bus width constants EXE_TO_MEM_W=212, MEM_TO_WB_W=207, MEM_TO_ID_W=39.
- One combinational sub-module, mem_load_align, with inputs rdata, addr[1:0], ld_type and output the 32-bit result.

Test Plan:
- ld.b at addr 0x1003, rdata 0x80FF1234, data_ok same cycle as MEM entry -> final_result 0xFFFFFF80, MEM_to_WB_valid that cycle.
- ld.hu at addr 0x1002, rdata 0x8001ABCD, data_ok 3 cycles late -> load_stall=1 for 3 cycles, then final_result 0x00008001.
- data_ok arrives while WB_allow_in=0 -> buf_valid=1; WB_allow_in rises 2 cycles later -> buffered value delivered, buf_valid=0.
- Flush while load waiting and exe_killed_req=1 -> discard_cnt=2. Next two data_ok are dropped. A following ld.w completes only on its own (third) data_ok.
- Load with ex_type[TYPE_ALE]=1, alu_result 0x1001 -> no wait, final_result 0x1001, fwd_we=0, mem_block=1.
- Reset asserted mid-wait -> next cycle MEM_valid=0, discard_cnt=0, MEM_allow_in=1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the MEM stage and its neighbours.
// Holds the exception type indices, the exception codes, the load-type
// encodings, the inter-stage bus widths and packed views of those buses.
package cpu_defs;

    localparam int EXE_TO_MEM_W = 212;
    localparam int MEM_TO_WB_W  = 207;
    localparam int MEM_TO_ID_W  = 39;

    // Bit positions inside ex_type[14:0]
    localparam int TYPE_INT    = 0;
    localparam int TYPE_ADEF   = 1;
    localparam int TYPE_TLBR_F = 2;
    localparam int TYPE_PIF    = 3;
    localparam int TYPE_PPI_F  = 4;
    localparam int TYPE_SYS    = 5;
    localparam int TYPE_BRK    = 6;
    localparam int TYPE_INE    = 7;
    localparam int TYPE_IPE    = 8;
    localparam int TYPE_ALE    = 9;
    localparam int TYPE_ADEM   = 10;
    localparam int TYPE_TLBR_M = 11;
    localparam int TYPE_PIL    = 12;
    localparam int TYPE_PIS    = 13;
    localparam int TYPE_PME    = 14;

    localparam logic [5:0] EXC_ECODE_INT  = 6'h00;
    localparam logic [5:0] EXC_ECODE_PIL  = 6'h01;
    localparam logic [5:0] EXC_ECODE_PIS  = 6'h02;
    localparam logic [5:0] EXC_ECODE_PIF  = 6'h03;
    localparam logic [5:0] EXC_ECODE_PME  = 6'h04;
    localparam logic [5:0] EXC_ECODE_PPI  = 6'h07;
    localparam logic [5:0] EXC_ECODE_ADE  = 6'h08;
    localparam logic [5:0] EXC_ECODE_ALE  = 6'h09;
    localparam logic [5:0] EXC_ECODE_SYS  = 6'h0B;
    localparam logic [5:0] EXC_ECODE_BRK  = 6'h0C;
    localparam logic [5:0] EXC_ECODE_INE  = 6'h0D;
    localparam logic [5:0] EXC_ECODE_IPE  = 6'h0E;
    localparam logic [5:0] EXC_ECODE_TLBR = 6'h3F;

    localparam logic [8:0] EXC_ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] EXC_ESUBCODE_ADEM = 9'd1;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct packed {
        logic        refetch;
        logic        tlbsrch;
        logic        tlbrd;
        logic        tlbwr;
        logic        tlbfill;
        logic        tlbhit;
        logic [3:0]  tlbhit_idx;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic [14:0] ex_type;
        logic [31:0] final_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
    } mem_to_wb_t;

    typedef struct packed {
        logic       mem_req_sent;
        logic [2:0] ld_type;
        logic       res_from_mem;
        mem_to_wb_t wb;
    } exe_to_mem_t;

    typedef struct packed {
        logic        fwd_we;
        logic [4:0]  fwd_dest;
        logic [31:0] fwd_data;
        logic        load_stall;
    } mem_to_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side signals of the MEM stage: the EXE handshake and bus, the
// data-SRAM response, the WB handshake and bus, ID forwarding and flush.
// slave  : the MEM stage itself.
// master : the surrounding pipeline (EXE, SRAM, WB, ID).
interface mem_stage_if;
    import cpu_defs::*;

    logic                    EXE_to_MEM_valid;
    logic                    MEM_allow_in;
    logic [EXE_TO_MEM_W-1:0] EXE_to_MEM_bus;
    logic                    exe_killed_req;
    logic                    data_sram_data_ok;
    logic [31:0]             data_sram_rdata;
    logic                    WB_allow_in;
    logic                    MEM_to_WB_valid;
    logic [MEM_TO_WB_W-1:0]  MEM_to_WB_bus;
    logic [MEM_TO_ID_W-1:0]  MEM_to_ID_bus;
    logic                    mem_block;
    logic                    flush;

    modport slave (
        input  EXE_to_MEM_valid, EXE_to_MEM_bus, exe_killed_req,
               data_sram_data_ok, data_sram_rdata, WB_allow_in, flush,
        output MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus,
               MEM_to_ID_bus, mem_block
    );

    modport master (
        output EXE_to_MEM_valid, EXE_to_MEM_bus, exe_killed_req,
               data_sram_data_ok, data_sram_rdata, WB_allow_in, flush,
        input  MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus,
               MEM_to_ID_bus, mem_block
    );

endinterface

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the SRAM
// word and sign- or zero-extends it. Unknown load types behave as ld.w.
// Ports: rdata (SRAM word), addr (low address bits), ld_type, result.
module mem_load_align
    import cpu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_type,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign half_s = addr[1] ? rdata[31:16] : rdata[15:0];

    // Byte lane select
    always_comb begin
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
    end

    // Extension according to load type
    always_comb begin
        case (ld_type)
            LD_B:    result = {{24{byte_s[7]}}, byte_s};
            LD_BU:   result = {24'h000000, byte_s};
            LD_H:    result = {{16{half_s[15]}}, half_s};
            LD_HU:   result = {16'h0000, half_s};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the instruction from EXE, waits for its data-SRAM
// response, aligns load data, and presents the result to WB and ID.
// Responses owed by flushed instructions are counted and swallowed.
// Ports: clk, resetn (synchronous, active-low), pipe (mem_stage_if.slave).
module mem_stage
    import cpu_defs::*;
#(
    parameter int BUS_IN_W  = EXE_TO_MEM_W,
    parameter int BUS_OUT_W = MEM_TO_WB_W,
    parameter int DISCARD_W = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  pipe
);

    localparam int CW = DISCARD_W + 2;
    localparam logic [CW-1:0] CNT_MAX_C = CW'((1 << DISCARD_W) - 1);

    logic                 mem_valid_r;
    logic [BUS_IN_W-1:0]  bus_r;
    logic [31:0]          rdata_buf_r;
    logic                 buf_valid_r;
    logic [DISCARD_W-1:0] discard_cnt_r;

    exe_to_mem_t          exe_s;
    mem_to_wb_t           wb_out_s;
    mem_to_id_t           id_out_s;
    logic                 ex_s, need_data_s, cnt_zero_s, data_ok_live_s;
    logic                 got_s, ready_go_s, allow_in_s, to_wb_valid_s;
    logic                 handoff_s, capture_s, dec_s;
    logic [31:0]          load_word_s, aligned_s, final_s;
    logic [CW-1:0]        inc_s, cnt_sum_s;
    logic [DISCARD_W-1:0] cnt_next_s;

    assign exe_s          = bus_r;
    assign ex_s           = |exe_s.wb.ex_type;
    assign need_data_s    = exe_s.mem_req_sent & ~ex_s;
    assign cnt_zero_s     = (discard_cnt_r == {DISCARD_W{1'b0}});
    // A response only belongs to the MEM instruction when nothing is owed.
    assign data_ok_live_s = pipe.data_sram_data_ok & cnt_zero_s;
    assign got_s          = buf_valid_r | data_ok_live_s;
    assign ready_go_s     = ~need_data_s | got_s;
    assign allow_in_s     = ~mem_valid_r | (ready_go_s & pipe.WB_allow_in);
    assign to_wb_valid_s  = mem_valid_r & ready_go_s & ~pipe.flush;
    assign handoff_s      = to_wb_valid_s & pipe.WB_allow_in;
    assign capture_s      = data_ok_live_s & mem_valid_r & need_data_s
                          & ~buf_valid_r & ~pipe.WB_allow_in;
    assign dec_s          = pipe.data_sram_data_ok & ~cnt_zero_s;

    // Outstanding responses of this stage's and EXE's killed instructions.
    assign inc_s = {{(CW-1){1'b0}}, mem_valid_r & need_data_s & ~got_s}
                 + {{(CW-1){1'b0}}, pipe.exe_killed_req};

    assign load_word_s = buf_valid_r ? rdata_buf_r : pipe.data_sram_rdata;

    mem_load_align u_align (
        .rdata   (load_word_s),
        .addr    (exe_s.wb.final_result[1:0]),
        .ld_type (exe_s.ld_type),
        .result  (aligned_s)
    );

    assign final_s = (exe_s.res_from_mem & ~ex_s) ? aligned_s : exe_s.wb.final_result;

    // Next discard count: flush adds owed responses, each dropped response removes one
    always_comb begin
        cnt_sum_s = {2'b00, discard_cnt_r} - {{(CW-1){1'b0}}, dec_s};
        if (pipe.flush) begin
            cnt_sum_s = cnt_sum_s + inc_s;
        end else begin
            cnt_sum_s = cnt_sum_s;
        end
        if (cnt_sum_s > CNT_MAX_C) begin
            cnt_next_s = CNT_MAX_C[DISCARD_W-1:0];
        end else begin
            cnt_next_s = cnt_sum_s[DISCARD_W-1:0];
        end
    end

    // Result bus towards WB with the final result substituted
    always_comb begin
        wb_out_s              = exe_s.wb;
        wb_out_s.final_result = final_s;
    end

    assign id_out_s.fwd_we     = mem_valid_r & exe_s.wb.gr_we & ~ex_s;
    assign id_out_s.fwd_dest   = exe_s.wb.dest;
    assign id_out_s.fwd_data   = final_s;
    assign id_out_s.load_stall = mem_valid_r & exe_s.res_from_mem & ~ready_go_s;

    assign pipe.MEM_allow_in    = allow_in_s;
    assign pipe.MEM_to_WB_valid = to_wb_valid_s;
    assign pipe.MEM_to_WB_bus   = BUS_OUT_W'(wb_out_s);
    assign pipe.MEM_to_ID_bus   = id_out_s;
    assign pipe.mem_block       = mem_valid_r & (ex_s | exe_s.wb.ertn | exe_s.wb.refetch);

    // Stage valid and instruction capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_r <= 1'b0;
            bus_r       <= {BUS_IN_W{1'b0}};
        end else begin
            if (pipe.flush) begin
                mem_valid_r <= 1'b0;
            end else if (allow_in_s) begin
                mem_valid_r <= pipe.EXE_to_MEM_valid;
            end else begin
                mem_valid_r <= mem_valid_r;
            end
            if (pipe.EXE_to_MEM_valid & allow_in_s) begin
                bus_r <= pipe.EXE_to_MEM_bus;
            end else begin
                bus_r <= bus_r;
            end
        end
    end

    // Holds a response that arrived while WB was not ready
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid_r <= 1'b0;
            rdata_buf_r <= 32'h0000_0000;
        end else if (pipe.flush | handoff_s) begin
            buf_valid_r <= 1'b0;
        end else if (capture_s) begin
            buf_valid_r <= 1'b1;
            rdata_buf_r <= pipe.data_sram_rdata;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    // Count of SRAM responses still owed to killed instructions
    always_ff @(posedge clk) begin
        if (!resetn) begin
            discard_cnt_r <= {DISCARD_W{1'b0}};
        end else begin
            discard_cnt_r <= cnt_next_s;
        end
    end

endmodule
